// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller for a multi-cycle ALU datapath.
// Accepts one operation at a time, steps the bit-serial shifter for SHAMT
// cycles on shift opcodes, and holds decoded datapath controls until the
// consumer takes the result.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [3:0]     op_i,
    input  logic [SHW-1:0] shamt_i,
    output logic           load_o,
    output logic           cisel_o,
    output logic           bsel_o,
    output logic           shift_la_o,
    output logic           shift_lr_o,
    output logic [1:0]     logical_op_o,
    output logic [1:0]     osel_o,
    output logic           step_en_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic           illegal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic       cisel;
        logic       bsel;
        logic       shift_la;
        logic       shift_lr;
        logic [1:0] logical_op;
        logic [1:0] osel;
    } ctrl_t;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SRA    = 4'd2;
    localparam logic [3:0] OP_SRL    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_PASS_A = 4'd7;
    localparam logic [3:0] OP_XOR    = 4'd8;
    localparam logic [3:0] OP_SLT    = 4'd9;

    // Shift opcodes are the only ones that consume SHAMT.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
    endfunction

    // Opcode to datapath control decode. PASS_A routes through the adder
    // with B zeroed by the datapath, so it decodes like ADD.
    function automatic ctrl_t decode(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD, OP_PASS_A: c.osel = 2'b00;
            OP_SUB: begin
                c.cisel = 1'b1;
                c.bsel  = 1'b1;
            end
            OP_SRA: begin
                c.shift_la = 1'b1;
                c.osel     = 2'b01;
            end
            OP_SRL: begin
                c.shift_lr = 1'b1;
                c.osel     = 2'b01;
            end
            OP_SLL: c.osel = 2'b01;
            OP_AND: begin
                c.logical_op = 2'b01;
                c.osel       = 2'b10;
            end
            OP_OR:  c.osel = 2'b10;
            OP_XOR: begin
                c.logical_op = 2'b10;
                c.osel       = 2'b10;
            end
            OP_SLT: begin
                c.cisel = 1'b1;
                c.bsel  = 1'b1;
                c.osel  = 2'b11;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_e         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    ctrl_t          ctrl;
    logic           accept;
    logic           start;

    // Ready in IDLE, or in DONE when the current result is being consumed.
    assign in_ready_o = rst_n_i &&
                        ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;
    assign load_o     = accept;

    // Next-state, shift counter and opcode latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) start = 1'b1;
            end
            SHIFT: begin
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    if (accept) start = 1'b1;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            op_d = op_i;
            if (is_shift(op_i) && (shamt_i != '0)) begin
                state_d = SHIFT;
                cnt_d   = shamt_i;
            end else begin
                state_d = DONE;
                cnt_d   = '0;
            end
        end
    end

    // State, counter and latched opcode registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Controls are the decode of the latched opcode, forced to zero in IDLE.
    always_comb begin
        ctrl = '0;
        if (state_q != IDLE) ctrl = decode(op_q);
    end

    assign illegal_o    = ctrl.illegal;
    assign cisel_o      = ctrl.cisel;
    assign bsel_o       = ctrl.bsel;
    assign shift_la_o   = ctrl.shift_la;
    assign shift_lr_o   = ctrl.shift_lr;
    assign logical_op_o = ctrl.logical_op;
    assign osel_o       = ctrl.osel;
    assign step_en_o    = (state_q == SHIFT);
    assign out_valid_o  = (state_q == DONE);

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; the block SHALL operate correctly for any SHW consistent with WIDTH.
REQ-003 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 IN_VALID  in  1  operation request valid.
REQ-006 IN_READY  out  1  block can accept an operation this cycle.
REQ-007 OP  in  4  opcode: 0 ADD, 1 SUB, 2 SRA, 3 SRL, 4 SLL, 5 AND, 6 OR, 7 PASS_A, 8 XOR, 9 SLT; 10-15 illegal.
REQ-008 SHAMT  in  SHW  shift amount, sampled only with shift opcodes.
REQ-009 LOAD  out  1  datapath captures operands; equals IN_VALID & IN_READY.
REQ-010 CISEL, BSEL  out  1 each  adder carry-in / invert-B select.
REQ-011 SHIFT_LA, SHIFT_LR  out  1 each  arithmetic-right / logical-right shift select; both 0 = left.
REQ-012 LOGICAL_OP  out  2  00 OR, 01 AND, 10 XOR.
REQ-013 OSEL  out  2  result mux: 00 adder, 01 shifter, 10 logic, 11 compare (SLT).
REQ-014 STEP_EN  out  1  shifter performs one 1-bit shift this cycle.
REQ-015 OUT_VALID  out  1  result on datapath is final.
REQ-016 OUT_READY  in  1  consumer accepts result.
REQ-017 ILLEGAL  out  1  current result belongs to an illegal opcode.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-019 Accept SHALL occur on a rising edge where IN_VALID & IN_READY; OP and SHAMT SHALL be latched into internal registers at that edge.
REQ-020 IN_READY SHALL be 1 in IDLE, 1 in DONE when OUT_READY=1, else 0.
REQ-021 On accept of a shift opcode (2,3,4) with SHAMT>0 the FSM SHALL enter SHIFT with counter=SHAMT; otherwise it SHALL enter DONE.
REQ-022 In SHIFT, STEP_EN SHALL be 1 every cycle; counter SHALL decrement each edge; the FSM SHALL enter DONE on the edge where counter goes 1->0, giving exactly SHAMT STEP_EN cycles.
REQ-023 STEP_EN SHALL be 0 outside SHIFT.
REQ-024 Latency accept-edge to first OUT_VALID cycle SHALL be 1 cycle for non-shift and SHAMT=0 shifts, SHAMT+1 cycles otherwise.
REQ-025 In DONE, OUT_VALID SHALL be 1 and all control outputs SHALL hold until OUT_READY=1.
REQ-026 DONE with OUT_READY=1 and no new accept SHALL return to IDLE; with simultaneous accept SHALL follow REQ-021 (back-to-back, no bubble).
REQ-027 Control outputs SHALL be registered decodes of the latched opcode, valid in SHIFT and DONE: SUB and SLT CISEL=BSEL=1; SRA SHIFT_LA=1; SRL SHIFT_LR=1; AND LOGICAL_OP=01; XOR 10; OR and PASS_A 00; OSEL 01 for shifts, 10 for AND/OR/XOR, 11 for SLT, 00 otherwise (PASS_A: adder, BSEL=0, CISEL=0, datapath zeroes B).
REQ-028 In IDLE all control outputs SHALL be 0.
REQ-029 Illegal opcode SHALL be accepted, go to DONE, drive ILLEGAL=1 with all other controls 0; ILLEGAL SHALL be 0 otherwise.
REQ-030 SHAMT SHALL be ignored for non-shift opcodes; SHAMT changes after accept SHALL have no effect.
REQ-031 IN_VALID while IN_READY=0 SHALL be ignored (no latch, no LOAD).

Reset
REQ-032 RST_N low SHALL immediately force IDLE, counter 0, latched OP 0, and all outputs 0 except IN_READY, which SHALL be 0 while RST_N is low and 1 from the first cycle after release.
REQ-033 Reset during SHIFT or DONE SHALL abandon the operation; no OUT_VALID SHALL follow.

Verification
REQ-034 ADD then SUB, OUT_READY=1 -> LOAD each accept; OUT_VALID 1 cycle after each; SUB shows CISEL=BSEL=1, OSEL=00.
REQ-035 SRA SHAMT=5, WIDTH=32 -> STEP_EN 5 cycles, SHIFT_LA=1, OSEL=01, OUT_VALID on 6th cycle after accept.
REQ-036 SLL SHAMT=0 -> no STEP_EN, OUT_VALID 1 cycle after accept, OSEL=01.
REQ-037 XOR with OUT_READY=0 for 3 cycles -> OUT_VALID, LOGICAL_OP=10, OSEL=10 held 3 cycles, IN_READY=0; new op accepted same edge OUT_READY rises.
REQ-038 OP=12 -> OUT_VALID with ILLEGAL=1, other controls 0; next legal op ILLEGAL=0.
REQ-039 SRL SHAMT=31, RST_N low after 10 STEP_EN cycles -> all outputs 0 immediately, IDLE, no OUT_VALID.
